pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/adder_pkg.sv | 16 +
 rtl/adder_stage.sv | 38 +++
 rtl/pipe_adder.sv | 131 +++++++++++++
 tb/tb_pipe_adder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared configuration helpers for the chunked pipelined adder.
// Legality of the WIDTH/CHUNK split and the resulting stage count live here.
package adder_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  function automatic bit cfg_legal(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

  function automatic int calc_stages(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/adder_stage.sv
// CHUNK-bit adder slice with registered sum and carry; one cycle of latency.
// Registers hold their value whenever en_i is low, so a stalled pipeline freezes in place.
module adder_stage
  import adder_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] s_o,
  output logic             c_o
);

  logic [CHUNK-1:0] s_q, s_d;
  logic             c_q, c_d;

  always_comb begin
    {c_d, s_d} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, c_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_q <= '0;
      c_q <= 1'b0;
    end else if (en_i) begin
      s_q <= s_d;
      c_q <= c_d;
    end
  end

  assign s_o = s_q;
  assign c_o = c_q;

endmodule

// File: rtl/pipe_adder.sv
// Carry-pipelined add/subtract, CHUNK bits per stage; latency WIDTH/CHUNK cycles, one result per cycle.
// Whole pipeline advances together when the output slot is free or being taken; otherwise every stage holds.
module pipe_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int STAGES = calc_stages(WIDTH, CHUNK);

  if (!cfg_legal(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [STAGES-1:0] vld_q, vld_d;
  logic             a_msb_q, b_msb_q;

  assign adv      = ~rst & (out_ready | ~out_valid);
  assign in_ready = adv;
  assign b_eff    = sub ? ~b : b;
  assign cin_eff  = sub | c_in;

  always_comb begin
    vld_d    = vld_q;
    vld_d[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      vld_d[k] = vld_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q <= vld_d;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    // Operand bits from chunk k upward still waiting to be added.
    localparam int IW = WIDTH - CHUNK * k;

    logic [IW-1:0]          a_in, b_in;
    logic                   c_in_k;
    logic [CHUNK-1:0]       sum_k;
    logic                   c_out_k;
    logic [CHUNK*(k+1)-1:0] res_w;

    if (k == 0) begin : g_head
      assign a_in   = a;
      assign b_in   = b_eff;
      assign c_in_k = cin_eff;
      assign res_w  = sum_k;
    end else begin : g_body
      logic [CHUNK*k-1:0] lo_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          lo_q <= '0;
        end else if (adv) begin
          lo_q <= g_st[k-1].res_w;
        end
      end

      assign a_in   = g_st[k-1].g_hi.a_hi_q;
      assign b_in   = g_st[k-1].g_hi.b_hi_q;
      assign c_in_k = g_st[k-1].c_out_k;
      assign res_w  = {sum_k, lo_q};
    end

    if (k < STAGES - 1) begin : g_hi
      logic [IW-CHUNK-1:0] a_hi_q, b_hi_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_hi_q <= '0;
          b_hi_q <= '0;
        end else if (adv) begin
          a_hi_q <= a_in[IW-1:CHUNK];
          b_hi_q <= b_in[IW-1:CHUNK];
        end
      end
    end

    adder_stage #(.CHUNK(CHUNK)) u_stage (
      .clk_i (clk),
      .rst_i (rst),
      .en_i  (adv),
      .a_i   (a_in[CHUNK-1:0]),
      .b_i   (b_in[CHUNK-1:0]),
      .c_i   (c_in_k),
      .s_o   (sum_k),
      .c_o   (c_out_k)
    );
  end

  // Operand sign bits captured alongside the top chunk's sum for overflow detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else if (adv) begin
      a_msb_q <= g_st[STAGES-1].a_in[CHUNK-1];
      b_msb_q <= g_st[STAGES-1].b_in[CHUNK-1];
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign s         = g_st[STAGES-1].res_w;
  assign c_out     = g_st[STAGES-1].c_out_k;
  assign ovf       = (a_msb_q == b_msb_q) & (s[WIDTH-1] != a_msb_q);

endmodule

// File: tb/tb_pipe_adder.sv
// Randomised and directed bench for pipe_adder (WIDTH=16, CHUNK=4) against an integer-arithmetic model.
module tb_pipe_adder;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out, ovf;
  logic [15:0] a, b, s;

  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];
  logic [17:0] obs_q[$];

  // Directed vectors: a, b, c_in, sub and the required {s, c_out, ovf}.
  logic [15:0] va[6] = '{16'h0002, 16'hFFFF, 16'h0005, 16'h7FFF, 16'h0007, 16'h8000};
  logic [15:0] vb[6] = '{16'h0003, 16'h0001, 16'h0007, 16'h0001, 16'h0005, 16'h0001};
  logic        vc[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic        vs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [15:0] es[6] = '{16'h0005, 16'h0000, 16'hFFFE, 16'h8000, 16'h0002, 16'h7FFF};
  logic        ec[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic        eo[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  pipe_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // Plain integer arithmetic: unsigned result for s/c_out, signed range test for ovf.
  function automatic logic [17:0] model(input logic [15:0] op_a, input logic [15:0] op_b,
                                        input logic ci, input logic is_sub);
    int ua, ub, sa, sbv, u, r;
    logic [15:0] sum;
    logic co, ov;
    ua  = int'(op_a);
    ub  = int'(op_b);
    sa  = int'($signed(op_a));
    sbv = int'($signed(op_b));
    if (is_sub) begin
      u  = ua - ub;
      r  = sa - sbv;
      co = (ua >= ub);
    end else begin
      u  = ua + ub + int'(ci);
      r  = sa + sbv + int'(ci);
      co = (u > 65535);
    end
    sum = u[15:0];
    ov  = (r > 32767) || (r < -32768);
    return {sum, co, ov};
  endfunction

  // One cycle: drive at the falling edge, sample handshakes just after, advance to the next falling edge.
  task automatic drive(input logic r, input logic v, input logic [15:0] aa, input logic [15:0] bb,
                       input logic ci, input logic sb, input logic ordy,
                       output logic rdy, output logic stl, output logic [17:0] dat);
    rst = r; in_valid = v; a = aa; b = bb; c_in = ci; sub = sb; out_ready = ordy;
    #1;
    rdy = in_ready;
    stl = !r && out_valid && !out_ready;
    dat = {s, c_out, ovf};
    if (!r && v && in_ready) exp_q.push_back(model(aa, bb, ci, sb));
    if (!r && out_valid && out_ready) obs_q.push_back({s, c_out, ovf});
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic rdy, stl;
    logic [17:0] dat;
    drive(1'b1, 1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, rdy, stl, dat);
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", rdy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (s !== 16'h0000) begin errors++; $display("FAIL reset_s: got %h want 0000", s); end
    checks++; if ({c_out, ovf} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {c_out, ovf}); end
    for (int n = 0; n < 5; n++) begin
      drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, rdy, stl, dat);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_no_capture: got out_valid=%b want 0", out_valid); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_directed();
    logic rdy, stl, want_v;
    logic [17:0] dat;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, va[i], vb[i], vc[i], vs[i], 1'b1, rdy, stl, dat);
      for (int n = 1; n <= 4; n++) begin
        want_v = (n == 4);
        checks++;
        if (out_valid !== want_v) begin
          errors++; $display("FAIL latency[%0d] cycle %0d: got out_valid=%b want %b", i, n, out_valid, want_v);
        end
        if (n == 4) begin
          checks++; if (s !== es[i]) begin errors++; $display("FAIL directed_s[%0d]: got %h want %h", i, s, es[i]); end
          checks++; if (c_out !== ec[i]) begin errors++; $display("FAIL directed_cout[%0d]: got %b want %b", i, c_out, ec[i]); end
          checks++; if (ovf !== eo[i]) begin errors++; $display("FAIL directed_ovf[%0d]: got %b want %b", i, ovf, eo[i]); end
        end
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, rdy, stl, dat);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [15:0] ba[8], bb[8];
    logic rdy, stl, ordy, stall_p;
    logic [17:0] dat, held;
    int sent, cyc, idx;
    sent = 0; cyc = 0; stall_p = 1'b0; held = '0;
    for (int i = 0; i < 8; i++) begin ba[i] = 16'($urandom); bb[i] = 16'($urandom); end
    exp_q.delete(); obs_q.delete();
    while ((obs_q.size() < 8) && (cyc < 60)) begin
      if (stall_p) begin
        checks++;
        if ({out_valid, s, c_out, ovf} !== {1'b1, held}) begin
          errors++; $display("FAIL b2b_hold: got %b/%h want 1/%h", out_valid, {s, c_out, ovf}, held);
        end
      end
      ordy = !((cyc >= 3) && (cyc <= 5));
      idx  = (sent < 8) ? sent : 0;
      drive(1'b0, sent < 8, ba[idx], bb[idx], 1'b0, 1'b0, ordy, rdy, stl, dat);
      if ((cyc == 4) || (cyc == 5)) begin
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL b2b_stall_ready cycle %0d: got %b want 0", cyc, rdy); end
      end
      if (rdy && (sent < 8)) sent++;
      stall_p = stl; held = dat;
      cyc++;
    end
    checks++; if (obs_q.size() != 8) begin errors++; $display("FAIL b2b_count: got %0d want 8", obs_q.size()); end
    checks++; if (exp_q.size() != 8) begin errors++; $display("FAIL b2b_accepted: got %0d want 8", exp_q.size()); end
    for (int i = 0; i < 8; i++) begin
      if ((i < obs_q.size()) && (i < exp_q.size())) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_result[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_midflight();
    logic rdy, stl, want_v;
    logic [17:0] dat;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1, rdy, stl, dat);
    drive(1'b1, 1'b1, 16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b1, rdy, stl, dat);
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL midrst_in_ready: got %b want 0", rdy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    exp_q.delete(); obs_q.delete();
    for (int n = 0; n < 6; n++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale cycle %0d: got out_valid=%b want 0", n, out_valid); end
      drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, rdy, stl, dat);
    end
    drive(1'b0, 1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1, rdy, stl, dat);
    for (int n = 1; n <= 4; n++) begin
      want_v = (n == 4);
      checks++;
      if (out_valid !== want_v) begin errors++; $display("FAIL midrst_latency cycle %0d: got %b want %b", n, out_valid, want_v); end
      if (n == 4) begin
        checks++;
        if ({s, c_out, ovf} !== {16'h2345, 1'b0, 1'b0}) begin
          errors++; $display("FAIL midrst_result: got %h/%b/%b want 2345/0/0", s, c_out, ovf);
        end
      end
      drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, rdy, stl, dat);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random();
    logic rdy, stl, stall_p, v, ordy;
    logic [15:0] ra, rb;
    logic [17:0] dat, held;
    int n;
    stall_p = 1'b0; held = '0;
    exp_q.delete(); obs_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (stall_p) begin
        checks++;
        if ({out_valid, s, c_out, ovf} !== {1'b1, held}) begin
          errors++; $display("FAIL rand_hold cycle %0d: got %b/%h want 1/%h", cyc, out_valid, {s, c_out, ovf}, held);
        end
      end
      v    = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 7);
      ra   = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 3)) : 16'($urandom);
      rb   = 16'($urandom);
      drive(1'b0, v, ra, rb, 1'($urandom), 1'($urandom), ordy, rdy, stl, dat);
      stall_p = stl; held = dat;
    end
    n = 0;
    while ((obs_q.size() < exp_q.size()) && (n < 40)) begin
      drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, rdy, stl, dat);
      n++;
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count: got %0d results want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs_q.size()) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_result[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
